// File: rtl/add_round_key.sv
// AES AddRoundKey stage: XORs each state with the round key chosen by its round tag.
// Two register stages, one state per cycle, in_ready drops combinationally on output stall.
module add_round_key #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_wr_en,
  input  logic [3:0]   key_wr_idx,
  input  logic [127:0] key_wr_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [3:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   out_round,
  output logic         out_last,
  output logic         out_err
);

  localparam int NK = NUM_ROUNDS + 1;

  logic [NK-1:0][127:0] key_bank;
  logic [NK-1:0]        key_written;

  logic         adv;
  logic         accept;
  logic [127:0] sel_key;
  logic         sel_written;

  logic         s1_vld;
  logic [127:0] s1_dat;
  logic [127:0] s1_key;
  logic [3:0]   s1_round;
  logic         s1_err;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  assign accept   = in_valid && in_ready;

  // An index beyond the bank never matches, so it reads as an unwritten all-zero key.
  always_comb begin
    sel_key     = '0;
    sel_written = 1'b0;
    for (int i = 0; i < NK; i++) begin
      if (in_round == 4'(i)) begin
        sel_key     = key_bank[i];
        sel_written = key_written[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_bank    <= '0;
      key_written <= '0;
    end else if (key_wr_en) begin
      for (int i = 0; i < NK; i++) begin
        if (key_wr_idx == 4'(i)) begin
          key_bank[i]    <= key_wr_data;
          key_written[i] <= 1'b1;
        end
      end
    end
  end

  // The key is snapshotted into S1 so later bank writes cannot disturb in-flight states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_dat    <= '0;
      s1_key    <= '0;
      s1_round  <= '0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_data  <= s1_dat ^ s1_key;
        out_round <= s1_round;
        out_last  <= (s1_round == 4'(NUM_ROUNDS));
        out_err   <= s1_err;
      end
      s1_vld <= accept;
      if (accept) begin
        s1_dat   <= in_data;
        s1_key   <= sel_key;
        s1_round <= in_round;
        s1_err   <= !sel_written;
      end
    end
  end

endmodule

// File: tb/tb_add_round_key.sv
// Randomized bench for add_round_key with a transaction-level scoreboard model.
module tb_add_round_key;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_wr_en;
  logic [3:0]   key_wr_idx;
  logic [127:0] key_wr_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_round;
  logic         out_last;
  logic         out_err;

  add_round_key #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_round(out_round), .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: key table plus an in-order queue of expected results.
  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   r;
    logic         l;
    logic         e;
  } exp_t;

  logic [127:0] m_key [0:15];
  bit           m_wr  [0:15];
  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] mon_k;
  bit           stall_prev = 0;
  logic [127:0] stall_dat;
  int           n_pop = 0;
  bit           rand_rdy = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 16; i++) begin
        m_key[i] = '0;
        m_wr[i]  = 0;
      end
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_data", out_data, stall_dat);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_out", out_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          n_pop++;
          check_val("sb_data", out_data, mon_e.d);
          check_val("sb_round", out_round, mon_e.r);
          check_val("sb_last", out_last, mon_e.l);
          check_val("sb_err", out_err, mon_e.e);
        end
      end
      // Accept sees the key as it stood before any write landing on the same edge.
      if (in_valid && in_ready) begin
        mon_k   = (in_round <= NR) ? m_key[in_round] : '0;
        mon_e.d = in_data ^ mon_k;
        mon_e.r = in_round;
        mon_e.l = (in_round == NR);
        mon_e.e = (in_round > NR) || !m_wr[in_round];
        sb.push_back(mon_e);
      end
      if (key_wr_en && key_wr_idx <= NR) begin
        m_key[key_wr_idx] = key_wr_data;
        m_wr[key_wr_idx]  = 1;
      end
      stall_prev = out_valid && !out_ready;
      stall_dat  = out_data;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [3:0] idx, input logic [127:0] dat);
    key_wr_en   = 1'b1;
    key_wr_idx  = idx;
    key_wr_data = dat;
    tick();
    key_wr_en = 1'b0;
  endtask

  // Presents one state and returns once it has been taken; in_valid stays high.
  task automatic send(input logic [127:0] d, input logic [3:0] r, output int tries);
    bit acc;
    acc      = 0;
    tries    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_round = r;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      tries++;
      if (acc) break;
    end
    if (!acc) check_val("timeout_in_ready", in_ready, 1);
  endtask

  task automatic wait_out(output int lat, output logic [127:0] d,
                          output logic l, output logic e);
    lat = 1;
    d   = '0;
    l   = 1'b0;
    e   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      tick();
      lat++;
    end
    if (!out_valid) check_val("timeout_out_valid", out_valid, 1);
    d = out_data;
    l = out_last;
    e = out_err;
  endtask

  task automatic one_state(input logic [127:0] d, input logic [3:0] r, output int lat,
                           output logic [127:0] od, output logic ol, output logic oe);
    int tries;
    send(d, r, tries);
    in_valid = 1'b0;
    wait_out(lat, od, ol, oe);
    tick();
  endtask

  initial begin
    int           lat, tries, sum, pop0;
    logic [127:0] od, d;
    logic         ol, oe;

    rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    in_valid = 1'b0; in_data = '0; in_round = '0; out_ready = 1'b1;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_round", out_round, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_out_err", out_err, 0);
    #21 rst = 1'b0;
    tick();
    check_val("post_rst_in_ready", in_ready, 1);

    write_key(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    write_key(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    one_state(128'h3243f6a8885a308d313198a2e0370734, 4'd0, lat, od, ol, oe);
    check_val("fips_r0_latency", lat, 2);
    check_val("fips_r0_data", od, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check_val("fips_r0_err", oe, 0);
    check_val("fips_r0_last", ol, 0);
    one_state(128'h046681e5e0cb199a48f8d37a2806264c, 4'd1, lat, od, ol, oe);
    check_val("fips_r1_data", od, 128'ha49c7ff2689f352b6b5bea43026a5049);

    d = {$urandom, $urandom, $urandom, $urandom};
    one_state(d, 4'd11, lat, od, ol, oe);
    check_val("illegal_err", oe, 1);
    check_val("illegal_data", od, d);
    one_state({$urandom, $urandom, $urandom, $urandom}, 4'd5, lat, od, ol, oe);
    check_val("unwritten_err", oe, 1);
    write_key(4'd10, {$urandom, $urandom, $urandom, $urandom});
    one_state({$urandom, $urandom, $urandom, $urandom}, 4'd10, lat, od, ol, oe);
    check_val("last_flag", ol, 1);
    check_val("last_err", oe, 0);

    write_key(4'd3, '0);
    d = {$urandom, $urandom, $urandom, $urandom};
    key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = '1;
    send(d, 4'd3, tries);
    key_wr_en = 1'b0;
    in_valid  = 1'b0;
    wait_out(lat, od, ol, oe);
    check_val("same_cycle_old_key", od, d);
    tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    one_state(d, 4'd3, lat, od, ol, oe);
    check_val("same_cycle_new_key", od, ~d);

    for (int i = 0; i <= NR; i++) write_key(4'(i), {$urandom, $urandom, $urandom, $urandom});

    sum = 0;
    for (int i = 0; i < 8; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, NR)), tries);
      sum += tries;
    end
    in_valid = 1'b0;
    check_val("throughput_edges", sum, 8);
    repeat (4) tick();

    pop0 = n_pop;
    rand_rdy = 1;
    for (int i = 0; i < 20; i++)
      send({$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, NR + 2)), tries);
    in_valid = 1'b0;
    for (int k = 0; k < 400 && sb.size() != 0; k++) tick();
    check_val("stream_drained", sb.size(), 0);
    check_val("stream_count", n_pop - pop0, 20);
    rand_rdy = 0;
    tick();
    out_ready = 1'b1;
    tick();

    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, 4'd2, tries);
    send({$urandom, $urandom, $urandom, $urandom}, 4'd4, tries);
    in_valid = 1'b0;
    check_val("full_backpressure", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    one_state({$urandom, $urandom, $urandom, $urandom}, 4'd0, lat, od, ol, oe);
    check_val("after_rst_err", oe, 1);
    write_key(4'd0, {$urandom, $urandom, $urandom, $urandom});
    one_state({$urandom, $urandom, $urandom, $urandom}, 4'd0, lat, od, ol, oe);
    check_val("rewritten_err", oe, 0);
    repeat (3) tick();
    check_val("final_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
